// File: rtl/ex_divider_pkg.sv
// Shared definitions for the execute-stage divider: state encodings,
// handshake levels, result bus type and iteration count.
package ex_divider_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam int DIV_RESULT_W = 64;
    typedef logic [DIV_RESULT_W-1:0] div_result_t;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam int DIV_CNT_W = 6;
    localparam logic [DIV_CNT_W-1:0] DIV_ITERATIONS = 6'd32;

    // Two's-complement negate of a 32-bit word.
    function automatic logic [31:0] negate32(input logic [31:0] value);
        return ~value + 32'd1;
    endfunction

endpackage

// File: rtl/ex_divider_step.sv
// One restoring-division iteration. The 64-bit work register holds
// {partial remainder, dividend/quotient}; shifting it left by one exposes a
// 33-bit partial remainder which is trial-subtracted by the divisor.
module div_step
    import ex_divider_pkg::*;
(
    input  logic [63:0] work_in,
    input  logic [31:0] divisor,
    output logic [63:0] work_out
);

    logic [32:0] trial;

    // Trial subtract; a clear sign bit means the divisor fits and the quotient bit is 1.
    always_comb begin
        trial = work_in[63:31] - {1'b0, divisor};
        if (!trial[32]) begin
            work_out = {trial[31:0], work_in[30:0], 1'b1};
        end else begin
            work_out = {work_in[62:31], work_in[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_divider.sv
// Multi-cycle 32-bit signed/unsigned divider for the EX stage. Produces
// {remainder, quotient} for HI/LO after 32 restoring iterations; divide by
// zero short-circuits to a zero result. Operands are converted to magnitudes
// on start and the signs are reapplied once at the end.
module ex_divider
    import ex_divider_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        signed_div_input,
    input  logic [31:0] dividend_input,
    input  logic [31:0] divisor_input,
    input  logic        start_input,
    input  logic        annul_input,
    output logic [63:0] result_output,
    output logic        ready_output,
    output logic        busy_output
);

    div_state_t           state, state_next;
    logic [DIV_CNT_W-1:0] counter, counter_next;
    logic [63:0]          work, work_next;
    logic [31:0]          divisor_mag, divisor_mag_next;
    logic                 neg_quot, neg_quot_next;
    logic                 neg_rem, neg_rem_next;
    div_result_t          result, result_next;
    logic                 ready, ready_next;

    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;
    logic [63:0] step_out;

    div_step u_step (
        .work_in  (work),
        .divisor  (divisor_mag),
        .work_out (step_out)
    );

    // Operand magnitudes for signed division; unsigned passes straight through.
    always_comb begin
        dividend_abs = (signed_div_input && dividend_input[31]) ? negate32(dividend_input) : dividend_input;
        divisor_abs  = (signed_div_input && divisor_input[31])  ? negate32(divisor_input)  : divisor_input;
    end

    // State register and datapath registers; reset clears everything at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= DivFree;
            counter     <= '0;
            work        <= '0;
            divisor_mag <= '0;
            neg_quot    <= 1'b0;
            neg_rem     <= 1'b0;
            result      <= '0;
            ready       <= DivResultNotReady;
        end else begin
            state       <= state_next;
            counter     <= counter_next;
            work        <= work_next;
            divisor_mag <= divisor_mag_next;
            neg_quot    <= neg_quot_next;
            neg_rem     <= neg_rem_next;
            result      <= result_next;
            ready       <= ready_next;
        end
    end

    // Next-state and datapath updates; annul takes priority in every state.
    always_comb begin
        state_next       = state;
        counter_next     = counter;
        work_next        = work;
        divisor_mag_next = divisor_mag;
        neg_quot_next    = neg_quot;
        neg_rem_next     = neg_rem;
        result_next      = result;
        ready_next       = ready;

        case (state)
            DivFree: begin
                if (start_input == DivStart && !annul_input) begin
                    work_next        = {32'd0, dividend_abs};
                    divisor_mag_next = divisor_abs;
                    neg_quot_next    = signed_div_input && (dividend_input[31] ^ divisor_input[31]);
                    neg_rem_next     = signed_div_input && dividend_input[31];
                    counter_next     = '0;
                    state_next       = (divisor_input == 32'd0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                if (annul_input) begin
                    state_next = DivFree;
                end else begin
                    result_next = '0;
                    ready_next  = DivResultReady;
                    state_next  = DivEnd;
                end
            end
            DivOn: begin
                if (annul_input) begin
                    counter_next = '0;
                    state_next   = DivFree;
                end else if (counter != DIV_ITERATIONS) begin
                    work_next    = step_out;
                    counter_next = counter + 1'b1;
                end else begin
                    result_next[63:32] = neg_rem  ? negate32(work[63:32]) : work[63:32];
                    result_next[31:0]  = neg_quot ? negate32(work[31:0])  : work[31:0];
                    ready_next         = DivResultReady;
                    state_next         = DivEnd;
                end
            end
            DivEnd: begin
                if (annul_input || start_input == DivStop) begin
                    result_next = '0;
                    ready_next  = DivResultNotReady;
                    state_next  = DivFree;
                end
            end
            default: begin
                state_next = DivFree;
            end
        endcase
    end

    assign result_output = result;
    assign ready_output  = ready;
    assign busy_output   = (state == DivOn) || (state == DivByZero);

endmodule

// File: doc/ex_divider.md
# ex_divider

Multi-cycle 32-bit integer divider for the execute stage: serves DIV/DIVU by running one restoring-division iteration per clock and returns a 64-bit {remainder, quotient} pair for the HI/LO write path. It consumes operands that EX receives from the ID/EX pipeline register. It drives the ready indication that EX turns into a stall request back toward ID/EX and PC, holding the front of the pipeline until the result exists.

## Interface
Parameters: none; widths come from the shared defines.
- clock  in  1  — single system clock, all state updates on rising edge
- reset  in  1  — asynchronous, active-low; low forces every register to its reset value immediately
- signed_div_input  in  1  — 1 = signed DIV, 0 = unsigned DIVU; sampled with start
- dividend_input  in  32  — dividend (rs value), sampled with start
- divisor_input  in  32  — divisor (rt value), sampled with start
- start_input  in  1  — request; EX holds it high until ready_output is seen
- annul_input  in  1  — abort (pipeline flush/exception); wins over start
- result_output  out  64  — [63:32] remainder (HI), [31:0] quotient (LO); 0 unless ready
- ready_output  out  1  — result_output valid
- busy_output  out  1  — high while in ON or BY_ZERO

## Operation
- States: FREE, BY_ZERO, ON, END. Reset → FREE, result_output=0, ready_output=0, busy_output=0, counter=0.
- FREE: start=1 and annul=0 → latch operands. Divisor==0 → BY_ZERO; else → ON, counter=0.
- FREE: if signed and an operand is negative, its two's-complement magnitude is latched. Quotient-negate flag = signed & (dividend[31]^divisor[31]); remainder-negate flag = signed & dividend[31].
- ON, annul=1 → FREE, counter=0, no result.
- ON, counter<32 → one iteration: shift the {partial remainder, dividend} register left 1; trial = partial remainder − divisor magnitude (33-bit). Non-negative: remainder=trial, shift in quotient bit 1; else 0. counter+=1.
- ON, counter==32 → apply sign flags (two's-complement negate), register result_output, ready_output=1 → END.
- BY_ZERO: next edge → END, result_output=0, ready_output=1 (MIPS leaves HI/LO undefined; 0 is decided).
- END: result_output and ready_output held while start=1. start=0 or annul=1 → FREE; ready_output=0 and result_output=0 on that edge.
- Start held high in END does not restart; a new division needs start low for ≥1 cycle (EX guarantees this by dropping start once ready).
- Operand input changes after the start edge are ignored.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000 (wrap), remainder 0; no trap.

## Timing
- Edge t0: start sampled in FREE. Edges t1–t32: iterations. Edge t33: sign fix, ready_output=1. First cycle with ready high = 34th cycle counting the start cycle.
- Divide-by-zero: ready_output high after t1 (2nd cycle).
- EX stall = start_input & ~ready_output; pipeline advances in the cycle ready is high.
- busy_output high from after t0 until the edge entering END.
- annul asserted in any cycle: FREE after the next edge; ready_output never rises for that operation.
- Reset low mid-operation: immediate FREE with all outputs 0; the operation is discarded.

## Structure
- Shared defines: state encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultBus (63:0), DivStart/DivStop, DivResultReady/DivResultNotReady, iteration count 32.
- One sub-module: div_step — combinational single iteration (33-bit subtract, quotient bit, next partial remainder). The FSM, counter and sign handling stay in ex_divider.

## Test plan
- Unsigned 100 / 7 → ready on 34th cycle; result_output = 0x00000002_0000000E.
- Signed −7 (0xFFFFFFF9) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0, dividend 0x12345678 → ready on 2nd cycle; result_output = 0; busy_output high for 1 cycle.
- Signed 0x80000000 / 0xFFFFFFFF → result_output = 0x00000000_80000000. Unsigned 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
- Annul at cycle 10 of ON → FREE next edge, ready never rises. Then start low 1 cycle, start 9 / 3 → 0x00000000_00000003.
- Reset low at cycle 20 → outputs 0 without clock. After release, start 1000 / 10 → 0x00000000_00000064 on 34th cycle. Start held 5 cycles in END → result stable, no restart.
